// File: rtl/polyveck_power2round_pkg.sv
// Shared Dilithium constants and the power2round controller state type.
package polyveck_power2round_pkg;

  localparam int unsigned COEF_W = 32;
  localparam int          Q      = 8380417;
  localparam int unsigned D      = 13;
  localparam int          ROUND  = (1 << (D - 1)) - 1;
  localparam int unsigned K      = 6;
  localparam int unsigned N      = 256;
  localparam int unsigned P      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/polyveck_power2round_unit.sv
// Single-coefficient caddq followed by power2round split into high/low parts.
module power2round_unit
  import polyveck_power2round_pkg::*;
(
  input  logic signed [COEF_W-1:0] a,
  output logic signed [COEF_W-1:0] a1,
  output logic signed [COEF_W-1:0] a0
);

  logic signed [COEF_W-1:0] ap;

  assign ap = a[COEF_W-1] ? (a + Q) : a;
  assign a1 = (ap + ROUND) >>> D;
  assign a0 = ap - (a1 <<< D);

endmodule

// File: rtl/polyveck_power2round.sv
// Vector power2round: walks the K*N coefficients P at a time, one group per cycle.
module polyveck_power2round
  import polyveck_power2round_pkg::*;
#(
  parameter int unsigned K = polyveck_power2round_pkg::K,
  parameter int unsigned N = polyveck_power2round_pkg::N,
  parameter int unsigned P = polyveck_power2round_pkg::P
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic signed [K*N*COEF_W-1:0]      linear_v_in,
  output logic                              busy,
  output logic                              done,
  output logic signed [K*N*COEF_W-1:0]      linear_t1_out,
  output logic signed [K*N*COEF_W-1:0]      linear_t0_out
);

  localparam int unsigned GROUPS = (K * N) / P;
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned GRP_W  = P * COEF_W;
  localparam int unsigned VEC_W  = K * N * COEF_W;
  localparam int unsigned IDX_W  = $clog2(VEC_W);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     base_c;
  logic                 last_c;
  logic [GRP_W-1:0]     grp_in, grp_t1, grp_t0;
  logic signed [VEC_W-1:0] t1_q, t0_q;

  assign base_c = IDX_W'(cnt_q) * IDX_W'(GRP_W);
  assign last_c = (cnt_q == CNT_W'(GROUPS - 1));
  assign grp_in = linear_v_in[base_c +: GRP_W];

  for (genvar g = 0; g < P; g++) begin : g_unit
    power2round_unit u_unit (
      .a  (grp_in[g*COEF_W +: COEF_W]),
      .a1 (grp_t1[g*COEF_W +: COEF_W]),
      .a0 (grp_t0[g*COEF_W +: COEF_W])
    );
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the current group's slice is written; untouched slices keep old results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_q <= '0;
      t0_q <= '0;
    end else if (state_q == RUN) begin
      t1_q[base_c +: GRP_W] <= grp_t1;
      t0_q[base_c +: GRP_W] <= grp_t0;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign linear_t1_out = t1_q;
  assign linear_t0_out = t0_q;

endmodule

// File: tb/tb_polyveck_power2round.sv
// Randomised bench for polyveck_power2round against a division-based reference model.
module tb_polyveck_power2round;

  localparam int K  = 6;
  localparam int N  = 256;
  localparam int P  = 8;
  localparam int NC = K * N;
  localparam int WV = NC * 32;
  localparam int Q  = 8380417;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [WV-1:0] vin;
  logic                 busy;
  logic                 done;
  logic signed [WV-1:0] t1o;
  logic signed [WV-1:0] t0o;

  logic [WV-1:0] exp_t1;
  logic [WV-1:0] exp_t0;
  int checks = 0;
  int errors = 0;

  polyveck_power2round #(.K(K), .N(N), .P(P)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .linear_v_in   (vin),
    .busy          (busy),
    .done          (done),
    .linear_t1_out (t1o),
    .linear_t0_out (t0o)
  );

  always #5 clk = ~clk;

  function automatic int coef(input logic [WV-1:0] v, input int i);
    logic [31:0] w;
    w = v[32*i +: 32];
    return int'(w);
  endfunction

  function automatic int first_diff(input logic [WV-1:0] x, input logic [WV-1:0] y);
    for (int i = 0; i < NC; i++)
      if (coef(x, i) != coef(y, i)) return i;
    return 0;
  endfunction

  // Reference: t1 = floor((a' + 4095) / 2^13), t0 = a' - t1 * 2^13.
  task automatic model();
    int a, ap, h, l;
    for (int i = 0; i < NC; i++) begin
      a  = coef(vin, i);
      ap = (a < 0) ? a + Q : a;
      h  = (ap + 4095) / 8192;
      l  = ap - h * 8192;
      exp_t1[32*i +: 32] = h;
      exp_t0[32*i +: 32] = l;
    end
  endtask

  task automatic randomize_vin();
    int r;
    for (int i = 0; i < NC; i++) begin
      r = int'($urandom_range(2*Q - 2, 0)) - (Q - 1);
      vin[32*i +: 32] = r;
    end
  endtask

  task automatic run_dut(input bit extra, input bit stop_on_done,
                         output int done_at, output int n_done, output int n_busy);
    done_at = -1;
    n_done  = 0;
    n_busy  = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = extra && (i == 10 || i == 100);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
      if (stop_on_done && done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vin = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0/0", busy, done);
    end
    checks++;
    if (t1o !== '0 || t0o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: t1[0]=%0d t0[0]=%0d expected 0", coef(t1o, 0), coef(t0o, 0));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int da, nd, nb, idx;
    vin = '0;
    model();
    run_dut(1'b0, 1'b0, da, nd, nb);
    checks++;
    if (da != 193) begin errors++; $display("FAIL zero_latency: got %0d expected 193", da); end
    checks++;
    if (nb != 192) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 192", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
    checks++;
    if (t1o !== exp_t1 || t0o !== exp_t0) begin
      errors++;
      idx = first_diff(t1o, exp_t1);
      $display("FAIL zero_out coef %0d: t1 got %0d expected %0d, t0 got %0d expected %0d",
               idx, coef(t1o, idx), coef(exp_t1, idx), coef(t0o, idx), coef(exp_t0, idx));
    end
  endtask

  task automatic test_directed();
    int da, nd, nb, idx;
    int a_tab[4]  = '{-1, 4096, 4097, 8380416};
    int t1_tab[4] = '{1023, 0, 1, 1023};
    int t0_tab[4] = '{0, 4096, -4095, 0};
    for (int i = 0; i < NC; i++) vin[32*i +: 32] = a_tab[(i * 7 + i / 4) % 4];
    model();
    run_dut(1'b0, 1'b0, da, nd, nb);
    for (int i = 0; i < NC; i++) begin
      idx = (i * 7 + i / 4) % 4;
      checks++;
      if (coef(t1o, i) != t1_tab[idx] || coef(t0o, i) != t0_tab[idx]) begin
        errors++;
        if (errors < 10)
          $display("FAIL directed coef %0d (a=%0d): got (%0d,%0d) expected (%0d,%0d)",
                   i, a_tab[idx], coef(t1o, i), coef(t0o, i), t1_tab[idx], t0_tab[idx]);
      end
    end
    checks++;
    if (da != 193) begin errors++; $display("FAIL directed_latency: got %0d expected 193", da); end
  endtask

  task automatic test_random();
    int da, nd, nb, idx, bad;
    for (int r = 0; r < 2; r++) begin
      randomize_vin();
      model();
      run_dut(1'b0, 1'b0, da, nd, nb);
      checks++;
      if (t1o !== exp_t1) begin
        errors++;
        idx = first_diff(t1o, exp_t1);
        $display("FAIL random_t1 coef %0d: got %0d expected %0d", idx, coef(t1o, idx), coef(exp_t1, idx));
      end
      checks++;
      if (t0o !== exp_t0) begin
        errors++;
        idx = first_diff(t0o, exp_t0);
        $display("FAIL random_t0 coef %0d: got %0d expected %0d", idx, coef(t0o, idx), coef(exp_t0, idx));
      end
      bad = 0;
      for (int i = 0; i < NC; i++)
        if (coef(t1o, i) < 0 || coef(t1o, i) > 1023 || coef(t0o, i) < -4095 || coef(t0o, i) > 4096)
          bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL random_range: %0d coefficients out of range, expected 0", bad); end
    end
  endtask

  task automatic test_ignore_start();
    int da, nd, nb, idx;
    randomize_vin();
    model();
    run_dut(1'b1, 1'b0, da, nd, nb);
    checks++;
    if (da != 193 || nd != 1) begin
      errors++;
      $display("FAIL ignore_start_done: first at %0d count %0d expected 193 and 1", da, nd);
    end
    checks++;
    if (t1o !== exp_t1 || t0o !== exp_t0) begin
      errors++;
      idx = first_diff(t0o, exp_t0);
      $display("FAIL ignore_start_out coef %0d: t0 got %0d expected %0d", idx, coef(t0o, idx), coef(exp_t0, idx));
    end
  endtask

  task automatic test_reset_mid();
    int da, nd, nb, idx, bad;
    randomize_vin();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flags: busy=%b done=%b expected 0/0", busy, done);
    end
    checks++;
    if (t1o !== '0 || t0o !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: t1[0]=%0d t0[0]=%0d expected 0", coef(t1o, 0), coef(t0o, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (250) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_no_resume: %0d active cycles, expected 0", bad); end
    randomize_vin();
    model();
    run_dut(1'b0, 1'b0, da, nd, nb);
    checks++;
    if (da != 193 || t1o !== exp_t1 || t0o !== exp_t0) begin
      errors++;
      idx = first_diff(t1o, exp_t1);
      $display("FAIL reset_mid_rerun: done at %0d (exp 193), t1 coef %0d got %0d expected %0d",
               da, idx, coef(t1o, idx), coef(exp_t1, idx));
    end
  endtask

  task automatic test_back_to_back();
    int da, nd, nb, idx;
    randomize_vin();
    model();
    run_dut(1'b0, 1'b1, da, nd, nb);
    checks++;
    if (da != 193 || t1o !== exp_t1 || t0o !== exp_t0) begin
      errors++;
      idx = first_diff(t1o, exp_t1);
      $display("FAIL b2b_first: done at %0d (exp 193), t1 coef %0d got %0d expected %0d",
               da, idx, coef(t1o, idx), coef(exp_t1, idx));
    end
    randomize_vin();
    model();
    run_dut(1'b0, 1'b1, da, nd, nb);
    checks++;
    if (da != 193) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 193", da); end
    checks++;
    if (t1o !== exp_t1 || t0o !== exp_t0) begin
      errors++;
      idx = first_diff(t0o, exp_t0);
      $display("FAIL b2b_second_out coef %0d: t0 got %0d expected %0d", idx, coef(t0o, idx), coef(exp_t0, idx));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
